// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: command layout, opcodes and
// arbiter state encoding.
package ram_arb_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  // Opcode lives in the top two bits of every 10-bit command.
  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOCK_SPI  = 2'b01,
    ST_LOCK_HOST = 2'b10,
    ST_WAIT_RD   = 2'b11
  } state_e;

  // Address phases open a transaction and lock the RAM to their issuer.
  function automatic logic is_addr_op(input opcode_e op);
    return (op == OP_WR_ADDR) || (op == OP_RD_ADDR);
  endfunction

endpackage

// File: rtl/ram_arb_fifo.sv
// Show-ahead synchronous FIFO that buffers SPI commands. A push into a full
// FIFO is dropped (reported on drop) unless a pop frees a slot that cycle.
module ram_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping for this cycle's push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && !do_push;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the empty count already hides stale entries.
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates a buffered SPI command stream and a valid/ready host port onto a
// single-port RAM. Address commands lock the RAM to their issuer until the
// data phase; read-data commands wait for the RAM reply (bounded by a timeout)
// and route it back to whoever issued the read.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  spi_rx_data,
  input  logic              spi_rx_valid,
  output logic [DATA_W-1:0] spi_tx_data,
  output logic              spi_tx_valid,
  input  logic [CMD_W-1:0]  host_cmd,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [CMD_W-1:0]  ram_din,
  output logic              ram_rx_valid,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_tx_valid,
  output logic              spi_ovf,
  output logic              timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  state_e state_q, state_d;
  logic   last_host_q, last_host_d;
  logic   owner_host_q, owner_host_d;
  logic   run_q;
  logic [TW-1:0] timer_q, timer_d;

  logic [CMD_W-1:0]  ram_din_q, ram_din_d;
  logic              ram_rx_valid_q, ram_rx_valid_d;
  logic [DATA_W-1:0] spi_tx_data_q, spi_tx_data_d;
  logic              spi_tx_valid_q, spi_tx_valid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic              spi_ovf_q, spi_ovf_d;
  logic              timeout_err_q, timeout_err_d;

  logic [CMD_W-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_drop;
  logic             host_slot;
  logic             grant_host;
  logic             grant_spi;
  logic             issue;
  logic [CMD_W-1:0] issue_cmd;
  opcode_e          issue_op;

  ram_arb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_spi_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (spi_rx_valid),
    .din   (spi_rx_data),
    .pop   (grant_spi),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // Who may issue this cycle. The host slot does not depend on host_valid,
  // and stays closed during reset and the first cycle after release.
  always_comb begin
    host_slot = 1'b0;
    case (state_q)
      ST_IDLE:      host_slot = fifo_empty || !last_host_q;
      ST_LOCK_HOST: host_slot = 1'b1;
      default:      host_slot = 1'b0;
    endcase
    host_ready = run_q && host_slot;
    grant_host = host_ready && host_valid;
    grant_spi  = !grant_host && !fifo_empty &&
                 ((state_q == ST_IDLE) || (state_q == ST_LOCK_SPI));
    issue      = grant_host || grant_spi;
    issue_cmd  = grant_host ? host_cmd : fifo_dout;
    issue_op   = opcode_e'(issue_cmd[CMD_W-1 -: 2]);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    last_host_d    = last_host_q;
    owner_host_d   = owner_host_q;
    timer_d        = timer_q;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = issue;
    spi_tx_data_d  = spi_tx_data_q;
    spi_tx_valid_d = 1'b0;
    host_rdata_d   = host_rdata_q;
    host_rvalid_d  = 1'b0;
    spi_ovf_d      = spi_ovf_q | fifo_drop;
    timeout_err_d  = 1'b0;

    if (issue) ram_din_d = issue_cmd;

    case (state_q)
      ST_IDLE, ST_LOCK_SPI, ST_LOCK_HOST: begin
        if (issue) begin
          last_host_d  = grant_host;
          owner_host_d = grant_host;
          if (is_addr_op(issue_op)) begin
            state_d = grant_host ? ST_LOCK_HOST : ST_LOCK_SPI;
          end else if (issue_op == OP_WR_DATA) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RD;
            timer_d = '0;
          end
        end
      end
      ST_WAIT_RD: begin
        if (ram_tx_valid) begin
          if (owner_host_q) begin
            host_rdata_d  = ram_dout;
            host_rvalid_d = 1'b1;
          end else begin
            spi_tx_data_d  = ram_dout;
            spi_tx_valid_d = 1'b1;
          end
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
          timer_d       = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, arbitration history and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      last_host_q    <= 1'b1;
      owner_host_q   <= 1'b0;
      run_q          <= 1'b0;
      timer_q        <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      spi_tx_data_q  <= '0;
      spi_tx_valid_q <= 1'b0;
      host_rdata_q   <= '0;
      host_rvalid_q  <= 1'b0;
      spi_ovf_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_host_q    <= last_host_d;
      owner_host_q   <= owner_host_d;
      run_q          <= 1'b1;
      timer_q        <= timer_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      spi_tx_data_q  <= spi_tx_data_d;
      spi_tx_valid_q <= spi_tx_valid_d;
      host_rdata_q   <= host_rdata_d;
      host_rvalid_q  <= host_rvalid_d;
      spi_ovf_q      <= spi_ovf_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign spi_tx_data  = spi_tx_data_q;
  assign spi_tx_valid = spi_tx_valid_q;
  assign host_rdata   = host_rdata_q;
  assign host_rvalid  = host_rvalid_q;
  assign spi_ovf      = spi_ovf_q;
  assign timeout_err  = timeout_err_q;

endmodule
